// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux, 31x32 architectural register file ($0 hardwired),
// WB + jal-link write ports and two write-first combinational read ports.

// One read port: $0 forcing, then link bypass, then WB bypass, then storage.
module wb_regfile_rdport (
  input  logic [31:0][31:0] rf,
  input  logic [4:0]        addr,
  input  logic              byp_en,
  input  logic              link_we,
  input  logic [31:0]       link_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  output logic [31:0]       rdata
);
  // Link write is younger than the WB write, so it is checked first.
  always_comb begin
    rdata = rf[addr];
    if (addr == 5'd0) begin
      rdata = '0;
    end else if (byp_en) begin
      if (link_we && addr == 5'd31)
        rdata = link_data;
      else if (wb_we && addr == wb_addr)
        rdata = wb_data;
    end
  end
endmodule

module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteWB,
  input  logic        MemtoRegWB,
  input  logic [4:0]  regwriteaddrWB,
  input  logic [31:0] ALUoutWB,
  input  logic [31:0] memreaddataWB,
  input  logic        LinkWrite,
  input  logic [31:0] LinkData,
  input  logic [4:0]  rsaddr,
  input  logic [4:0]  rtaddr,
  output logic [31:0] rsdata,
  output logic [31:0] rtdata,
  output logic [31:0] wbdata
);
  localparam int NUM_RD = 2;

  logic [31:0] regs_q [31:1];
  logic [31:0] regs_d [31:1];
  logic [31:0][31:0] rf_view;
  logic [NUM_RD-1:0][4:0]  rd_addr;
  logic [NUM_RD-1:0][31:0] rd_data;

  // Write-back source select; driven regardless of RegWriteWB for EX forwarding.
  always_comb wbdata = MemtoRegWB ? memreaddataWB : ALUoutWB;

  // Next-state: WB write first, link write last so $31 collisions favour jal.
  always_comb begin
    regs_d = regs_q;
    if (RegWriteWB && regwriteaddrWB != 5'd0)
      regs_d[regwriteaddrWB] = wbdata;
    if (LinkWrite)
      regs_d[31] = LinkData;
  end

  // Storage: async clear to boot values ($gp/$sp preset), otherwise commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= (i == 28) ? GP_INIT : (i == 29) ? SP_INIT : 32'h0;
    end else begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  // Flat view of storage for the read ports; slot 0 has no storage.
  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < 32; i++)
      rf_view[i] = regs_q[i];
  end

  assign rd_addr = {rtaddr, rsaddr};

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    wb_regfile_rdport u_rd (
      .rf       (rf_view),
      .addr     (rd_addr[g]),
      .byp_en   (reset),
      .link_we  (LinkWrite),
      .link_data(LinkData),
      .wb_we    (RegWriteWB),
      .wb_addr  (regwriteaddrWB),
      .wb_data  (wbdata),
      .rdata    (rd_data[g])
    );
  end

  assign rsdata = rd_data[0];
  assign rtdata = rd_data[1];
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset contents, WB mux/commit, bypass,
// $0 behaviour, link/WB collisions and mid-cycle reset.
module tb_wb_regfile;
  localparam logic [31:0] SP = 32'h0000_3FFC;
  localparam logic [31:0] GP = 32'h0000_1800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWriteWB = 1'b0, MemtoRegWB = 1'b0, LinkWrite = 1'b0;
  logic [4:0]  regwriteaddrWB = '0, rsaddr = '0, rtaddr = '0;
  logic [31:0] ALUoutWB = '0, memreaddataWB = '0, LinkData = '0;
  logic [31:0] rsdata, rtdata, wbdata;

  int n_assert = 0;
  int n_fail   = 0;

  wb_regfile #(.SP_INIT(SP), .GP_INIT(GP)) dut (
    .clk(clk), .reset(reset),
    .RegWriteWB(RegWriteWB), .MemtoRegWB(MemtoRegWB),
    .regwriteaddrWB(regwriteaddrWB), .ALUoutWB(ALUoutWB),
    .memreaddataWB(memreaddataWB), .LinkWrite(LinkWrite), .LinkData(LinkData),
    .rsaddr(rsaddr), .rtaddr(rtaddr),
    .rsdata(rsdata), .rtdata(rtdata), .wbdata(wbdata)
  );

  always #5 clk = ~clk;

  task automatic idle();
    RegWriteWB = 1'b0; MemtoRegWB = 1'b0; LinkWrite = 1'b0;
    regwriteaddrWB = '0; ALUoutWB = '0; memreaddataWB = '0; LinkData = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic m2r, input logic [31:0] alu, input logic [31:0] mem);
    RegWriteWB = 1'b1; regwriteaddrWB = a; MemtoRegWB = m2r;
    ALUoutWB = alu; memreaddataWB = mem;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    #2 reset = 1'b0;
    wb(5'd5, 1'b0, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    LinkWrite = 1'b1; LinkData = 32'h0000_1111;
    @(posedge clk); #1;
    n_assert++;
    if (wbdata !== 32'hAAAA_AAAA) begin
      n_fail++; $display("FAIL reset_wbdata_mux got %h want %h", wbdata, 32'hAAAA_AAAA);
    end
    for (int i = 0; i < 32; i++) begin
      rsaddr = i[4:0]; rtaddr = 5'(31 - i); #1;
      exp = (i == 28) ? GP : (i == 29) ? SP : 32'h0;
      n_assert++;
      if (rsdata !== exp) begin
        n_fail++; $display("FAIL reset_rs[%0d] got %h want %h", i, rsdata, exp);
      end
      exp = ((31 - i) == 28) ? GP : ((31 - i) == 29) ? SP : 32'h0;
      n_assert++;
      if (rtdata !== exp) begin
        n_fail++; $display("FAIL reset_rt[%0d] got %h want %h", 31 - i, rtdata, exp);
      end
    end
    @(negedge clk); idle(); reset = 1'b1;
    rsaddr = 5'd5; rtaddr = 5'd31; #1;
    n_assert++;
    if (rsdata !== 32'h0 || rtdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_blocked_write got %h/%h want 0/0", rsdata, rtdata);
    end
  endtask

  task automatic test_wb_mux();
    @(negedge clk);
    wb(5'd5, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D); #1;
    n_assert++;
    if (wbdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL mux_alu got %h want %h", wbdata, 32'hDEAD_BEEF);
    end
    @(posedge clk); #1; idle(); rsaddr = 5'd5; #1;
    n_assert++;
    if (rsdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL commit_alu got %h want %h", rsdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    wb(5'd6, 1'b1, 32'h0BAD_F00D, 32'h1234_5678); #1;
    n_assert++;
    if (wbdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL mux_mem got %h want %h", wbdata, 32'h1234_5678);
    end
    @(posedge clk); #1; idle(); rtaddr = 5'd6; rsaddr = 5'd5; #1;
    n_assert++;
    if (rtdata !== 32'h1234_5678 || rsdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL commit_mem got %h/%h want 12345678/deadbeef", rtdata, rsdata);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wb(5'd7, 1'b0, 32'hCAFE_0001, 32'h0); rsaddr = 5'd7; rtaddr = 5'd7; #1;
    n_assert++;
    if (rsdata !== 32'hCAFE_0001 || rtdata !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL bypass_same_cycle got %h/%h want cafe0001", rsdata, rtdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    wb(5'd7, 1'b0, 32'hCAFE_0002, 32'h0); RegWriteWB = 1'b0; #1;
    n_assert++;
    if (rsdata !== 32'hCAFE_0001 || rtdata !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL bypass_disabled got %h/%h want cafe0001", rsdata, rtdata);
    end
    n_assert++;
    if (wbdata !== 32'hCAFE_0002) begin
      n_fail++; $display("FAIL wbdata_no_we got %h want %h", wbdata, 32'hCAFE_0002);
    end
    @(posedge clk); #1;
    n_assert++;
    if (rsdata !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL no_commit_without_we got %h want %h", rsdata, 32'hCAFE_0001);
    end
    idle();
  endtask

  task automatic test_zero();
    @(negedge clk);
    wb(5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0); rsaddr = 5'd0; rtaddr = 5'd0; #1;
    n_assert++;
    if (rsdata !== 32'h0 || rtdata !== 32'h0) begin
      n_fail++; $display("FAIL zero_same_cycle got %h/%h want 0", rsdata, rtdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_assert++;
      if (rsdata !== 32'h0) begin
        n_fail++; $display("FAIL zero_later[%0d] got %h want 0", c, rsdata);
      end
    end
    idle();
  endtask

  task automatic test_link();
    @(negedge clk);
    wb(5'd31, 1'b0, 32'h0000_0099, 32'h0);
    LinkWrite = 1'b1; LinkData = 32'h0000_0040; rsaddr = 5'd31; rtaddr = 5'd31; #1;
    n_assert++;
    if (rsdata !== 32'h40 || rtdata !== 32'h40) begin
      n_fail++; $display("FAIL link_collision_bypass got %h/%h want 40", rsdata, rtdata);
    end
    @(posedge clk); #1; idle(); #1;
    n_assert++;
    if (rsdata !== 32'h40) begin
      n_fail++; $display("FAIL link_collision_stored got %h want 40", rsdata);
    end
    @(negedge clk);
    wb(5'd4, 1'b0, 32'h0000_0099, 32'h0);
    LinkWrite = 1'b1; LinkData = 32'h0000_0044; rsaddr = 5'd31; rtaddr = 5'd4; #1;
    n_assert++;
    if (rsdata !== 32'h44 || rtdata !== 32'h99) begin
      n_fail++; $display("FAIL dual_write_bypass got %h/%h want 44/99", rsdata, rtdata);
    end
    @(posedge clk); #1; idle(); #1;
    n_assert++;
    if (rsdata !== 32'h44 || rtdata !== 32'h99) begin
      n_fail++; $display("FAIL dual_write_stored got %h/%h want 44/99", rsdata, rtdata);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wb(5'd10, 1'b0, 32'h0000_0055, 32'h0);
    @(posedge clk); #1; idle(); rsaddr = 5'd10; rtaddr = 5'd29; #1;
    n_assert++;
    if (rsdata !== 32'h55) begin
      n_fail++; $display("FAIL mid_pre_write got %h want 55", rsdata);
    end
    @(negedge clk);
    wb(5'd10, 1'b0, 32'h0000_0077, 32'h0);
    #1 reset = 1'b0; #1;
    n_assert++;
    if (rsdata !== 32'h0 || rtdata !== SP) begin
      n_fail++; $display("FAIL mid_reset_contents got %h/%h want 0/%h", rsdata, rtdata, SP);
    end
    #2 reset = 1'b1;
    @(posedge clk); #1; idle(); #1;
    n_assert++;
    if (rsdata !== 32'h77 || rtdata !== SP) begin
      n_fail++; $display("FAIL mid_first_write got %h/%h want 77/%h", rsdata, rtdata, SP);
    end
  endtask

  initial begin
    test_reset();
    test_wb_mux();
    test_bypass();
    test_zero();
    test_link();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back consumer and architectural register file for the five-stage MIPS pipeline. It takes the WB-stage bundle from the MEM/WB pipeline register: ALU result, load data, destination address, MemtoReg and RegWrite. It selects the write-back value, commits it on the clock edge, and serves two combinational read ports to the ID stage. A write-first bypass lets ID read a value in the same cycle WB writes it. A second write port commits the `jal` link address into $31 from ID.

## Interface
Parameters:
- SP_INIT, 32'h0000_3FFC, reset value of $29 ($sp)
- GP_INIT, 32'h0000_1800, reset value of $28 ($gp)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); one clock, reset is asynchronous and active-low
- RegWriteWB  in  1  WB-stage write enable
- MemtoRegWB  in  1  1 = write memreaddataWB, 0 = write ALUoutWB
- regwriteaddrWB  in  5  WB destination register
- ALUoutWB  in  32  WB ALU result
- memreaddataWB  in  32  WB load data
- LinkWrite  in  1  ID-stage `jal` link write enable (target fixed $31)
- LinkData  in  32  link value (PC+8)
- rsaddr  in  5  read port A address
- rtaddr  in  5  read port B address
- rsdata  out  32  read port A data (combinational)
- rtdata  out  32  read port B data (combinational)
- wbdata  out  32  selected write-back value, exported for the EX forwarding mux

## Operation
- Storage: 31 × 32-bit registers $1..$31. $0 has no storage, reads 0 and ignores writes.
- wbdata = MemtoRegWB ? memreaddataWB : ALUoutWB. It is always driven, whether or not RegWriteWB is set.
- WB commit: at posedge clk with reset high, RegWriteWB=1 and regwriteaddrWB≠0, the register regwriteaddrWB takes wbdata.
- Link commit: at posedge clk with reset high and LinkWrite=1, $31 takes LinkData.
- Same-edge collision: if both ports target $31, LinkData wins. The `jal` is younger in program order.
- Writes to different registers in the same edge both commit.
- Read port X (rs/rt), priority order:
  - address 0 → 0
  - else if LinkWrite and address = 31 → LinkData
  - else if RegWriteWB and address = regwriteaddrWB → wbdata
  - else the stored value
- Both read ports are independent and may hit the same register or bypass source simultaneously.
- Reset (reset=0, asynchronous): all registers clear to 0, except $28 = GP_INIT and $29 = SP_INIT.
  - Writes are blocked while reset is low.
  - Bypass is disabled while reset is low; reads return reset contents.
- Reset asserted mid-cycle discards any pending write. Deassertion takes effect at the next rising edge with no partial writes.

## Timing
- Write latency: 1 edge. The value is visible from storage in the cycle after the edge, and via bypass in the same cycle.
- Read latency: 0 cycles, combinational from rsaddr/rtaddr, write-port inputs and storage.
- No handshakes and no stalls; the block never backpressures the pipeline.
- Output values under reset: rsdata/rtdata equal the reset contents of the addressed register (0, GP_INIT or SP_INIT); wbdata follows its mux inputs.
- No combinational path from rsdata/rtdata back into the write ports.
- Hazards a bypass cannot resolve (load-use) are the hazard unit's responsibility, not this block's.

## Test plan
- Reset: drive reset=0 mid-cycle, then read all 32 addresses → $28 = 32'h0000_1800, $29 = 32'h0000_3FFC, all others 0. An attempted write during reset has no effect.
- WB mux and commit:
  - RegWriteWB=1, addr 5, MemtoRegWB=0, ALUoutWB=32'hDEAD_BEEF → next cycle rsaddr=5 reads DEADBEEF.
  - Repeat with MemtoRegWB=1, memreaddataWB=32'h1234_5678 into addr 6 → reads 12345678.
- Bypass: in the same cycle as a WB write of 32'hCAFE_0001 to $7, set rsaddr=rtaddr=7 → both ports return CAFE0001 before the edge. With RegWriteWB=0, both return the old value.
- $0: RegWriteWB=1, addr 0, data 32'hFFFF_FFFF → rsaddr=0 reads 0 in the same cycle and every later cycle.
- Link collision: LinkWrite=1, LinkData=32'h0000_0040, and in the same cycle a WB write to $31 of 32'h0000_0099 → same-cycle read of $31 = 0x40, stored $31 = 0x40. Separately, a link write plus a WB write to $4 of 0x99 commits both.
- Reset mid-operation: write $10 = 32'h55, then pulse reset low for 3 ns between edges → $10 reads 0 and $29 reads SP_INIT. The first write after deassertion commits normally.
